// File: rtl/morph_dilation_3x3.sv
// Streaming 3x3 grey-level dilation (windowed max) with two line buffers and end-of-frame flush.
// Define DILATION_CROSS_KERNEL_EN for a plus-shaped kernel; the default build uses the full 3x3 square.
module morph_dilation_3x3 #(
    parameter int unsigned IMG_WIDTH  = 752,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              erosion_valid,
    input  logic [DATA_W-1:0] erosion_dout,
    output logic              dilation_valid,
    output logic [DATA_W-1:0] dilation_dout,
    output logic              frame_done,
    output logic              overrun
);

    localparam int unsigned CW = $clog2(IMG_WIDTH + 1);
    localparam int unsigned AW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_in_col;
    logic [RW-1:0]     r_in_row;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_out_col;
    logic [DATA_W-1:0] r_lb_old [IMG_WIDTH];
    logic [DATA_W-1:0] r_lb_new [IMG_WIDTH];
    logic [DATA_W-1:0] r_v0;
    logic [DATA_W-1:0] r_v1;
`ifdef DILATION_CROSS_KERNEL_EN
    logic [DATA_W-1:0] r_c0;
    logic [DATA_W-1:0] r_c1;
`endif

    logic              w_flush;
    logic              w_step;
    logic              w_in_last_col;
    logic              w_in_last_row;
    logic              w_cnt_last;
    logic              w_out_last_col;
    logic [CW-1:0]     w_in_col_nx;
    logic [RW-1:0]     w_in_row_nx;
    logic [CW-1:0]     w_out_col_nx;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_mid;
    logic [DATA_W-1:0] w_bot;
    logic [DATA_W-1:0] w_vnew;
    logic [DATA_W-1:0] w_left;
    logic [DATA_W-1:0] w_right;
    logic [DATA_W-1:0] w_pix;

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Step control and raster counters
    always_comb begin
        w_flush        = (r_state == FLUSH);
        w_step         = w_flush || erosion_valid;
        w_in_last_col  = (r_in_col == CW'(IMG_WIDTH - 1));
        w_in_last_row  = (r_in_row == RW'(IMG_HEIGHT - 1));
        w_cnt_last     = (r_cnt == CW'(IMG_WIDTH));
        w_out_last_col = (r_out_col == CW'(IMG_WIDTH - 1));
        w_in_col_nx    = w_in_last_col ? '0 : r_in_col + CW'(1);
        w_in_row_nx    = r_in_row;
        if (w_in_last_col) begin
            w_in_row_nx = w_in_last_row ? '0 : r_in_row + RW'(1);
        end
        w_out_col_nx   = w_out_last_col ? '0 : r_out_col + CW'(1);
    end

    // Column vector of the incoming step: rows r-1, r, r+1 around the centre row of that column
    always_comb begin
        w_addr = AW'(r_in_col);
        if (w_flush) begin
            w_addr = w_cnt_last ? '0 : AW'(r_cnt);
        end
        w_mid  = r_lb_new[w_addr];
        w_top  = (!w_flush && (r_in_row == RW'(1))) ? '0 : r_lb_old[w_addr];
        w_bot  = w_flush ? '0 : erosion_dout;
        w_vnew = f_max(f_max(w_top, w_mid), w_bot);
    end

    // Horizontal combine; masked edge columns contribute 0, the identity for unsigned max
    always_comb begin
`ifdef DILATION_CROSS_KERNEL_EN
        w_left  = (r_out_col == '0) ? '0 : r_c1;
        w_right = w_out_last_col ? '0 : w_mid;
`else
        w_left  = (r_out_col == '0) ? '0 : r_v1;
        w_right = w_out_last_col ? '0 : w_vnew;
`endif
        w_pix   = f_max(f_max(w_left, r_v0), w_right);
    end

    // Line buffers are not reset; stale rows are masked by the row logic
    always_ff @(posedge s_axi_aclk) begin
        if (erosion_valid && !w_flush) begin
            r_lb_old[w_addr] <= w_mid;
            r_lb_new[w_addr] <= erosion_dout;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state        <= PRIME;
            r_in_col       <= '0;
            r_in_row       <= '0;
            r_cnt          <= '0;
            r_out_col      <= '0;
            r_v0           <= '0;
            r_v1           <= '0;
`ifdef DILATION_CROSS_KERNEL_EN
            r_c0           <= '0;
            r_c1           <= '0;
`endif
            dilation_valid <= 1'b0;
            dilation_dout  <= '0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            dilation_valid <= 1'b0;
            frame_done     <= 1'b0;
            if (w_flush && erosion_valid) begin
                overrun <= 1'b1;
            end
            if (w_step) begin
                r_v1 <= r_v0;
                r_v0 <= w_vnew;
`ifdef DILATION_CROSS_KERNEL_EN
                r_c1 <= r_c0;
                r_c0 <= w_mid;
`endif
            end
            case (r_state)
                PRIME: begin
                    if (erosion_valid) begin
                        r_in_col <= w_in_col_nx;
                        r_in_row <= w_in_row_nx;
                        if (w_cnt_last) begin
                            r_cnt   <= '0;
                            r_state <= RUN;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                RUN: begin
                    if (erosion_valid) begin
                        r_in_col       <= w_in_col_nx;
                        r_in_row       <= w_in_row_nx;
                        r_out_col      <= w_out_col_nx;
                        dilation_valid <= 1'b1;
                        dilation_dout  <= w_pix;
                        if (w_in_last_col && w_in_last_row) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    r_out_col      <= w_out_col_nx;
                    dilation_valid <= 1'b1;
                    dilation_dout  <= w_pix;
                    if (w_cnt_last) begin
                        r_cnt      <= '0;
                        frame_done <= 1'b1;
                        r_state    <= PRIME;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_morph_dilation_3x3.sv
// Randomized bench for morph_dilation_3x3 on an 8x4 frame against a direct windowed-max model.
module tb_morph_dilation_3x3;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ev;
    logic [7:0] ed;
    logic       dv;
    logic [7:0] dout;
    logic       fd;
    logic       ovr;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_in    = 0;
    int n_fd    = 0;
    int pix [N];
    int q_val [$];
    int q_fd  [$];
    int q_cyc [$];
    int q_nin [$];

    morph_dilation_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .erosion_valid  (ev),
        .erosion_dout   (ed),
        .dilation_valid (dv),
        .dilation_dout  (dout),
        .frame_done     (fd),
        .overrun        (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && ev) n_in <= n_in + 1;
    end

    always @(negedge clk) begin
        if (fd) n_fd <= n_fd + 1;
        if (dv) begin
            q_val.push_back(int'(dout));
            q_fd.push_back(int'(fd));
            q_cyc.push_back(cyc);
            q_nin.push_back(n_in);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int r, input int c);
        int m = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
`ifdef DILATION_CROSS_KERNEL_EN
                if (dr != 0 && dc != 0) continue;
`endif
                if (r + dr < 0 || r + dr >= H || c + dc < 0 || c + dc >= W) continue;
                if (pix[(r + dr) * W + c + dc] > m) m = pix[(r + dr) * W + c + dc];
            end
        end
        return m;
    endfunction

    // Entered and left at 1 time unit after a rising edge
    task automatic drive(input int n, input int gmax);
        for (int i = 0; i < n; i++) begin
            int g;
            g  = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
            ev = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            ev = 1'b1;
            ed = 8'(pix[i]);
            @(posedge clk); #1;
        end
        ev = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gmax, input bit inject, input int exp_ovr);
        int b_out;
        int b_in;
        int b_fd;
        int c0;
        int t;
        int cnt;
        int fsum;
        b_out = q_val.size();
        b_in  = n_in;
        b_fd  = n_fd;
        drive(N, gmax);
        c0 = cyc;
        if (inject) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            ev = 1'b1;
            ed = 8'hAA;
            @(posedge clk); #1;
            ev = 1'b0;
        end
        t = 0;
        while (q_val.size() - b_out < N && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) begin @(posedge clk); #1; end
        cnt = q_val.size() - b_out;
        chk({tag, "_count"}, cnt, N);
        if (cnt >= N) begin
            fsum = 0;
            for (int i = 0; i < N; i++) begin
                chk($sformatf("%s_px_%0d_%0d", tag, i / W, i % W), q_val[b_out + i], model(i / W, i % W));
                fsum += q_fd[b_out + i];
            end
            chk({tag, "_fd_last"}, q_fd[b_out + N - 1], 1);
            chk({tag, "_fd_sum"}, fsum, 1);
            chk({tag, "_first_after_in"}, q_nin[b_out] - b_in, W + 2);
            for (int j = 0; j <= W; j++) begin
                chk($sformatf("%s_flush_cyc_%0d", tag, j), q_cyc[b_out + N - 1 - W + j], c0 + 1 + j);
            end
        end
        chk({tag, "_fd_pulses"}, n_fd - b_fd, 1);
        chk({tag, "_overrun"}, int'(ovr), exp_ovr);
    endtask

    initial begin
        rst_n = 1'b0;
        ev    = 1'b0;
        ed    = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", int'(dv), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_fd", int'(fd), 0);
        chk("rst_ovr", int'(ovr), 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_idle_outputs", q_val.size(), 0);

        for (int i = 0; i < N; i++) pix[i] = 0;
        pix[2 * W + 3] = 200;
        run_frame("single23", 0, 1'b0, 0);

        for (int i = 0; i < N; i++) pix[i] = 0;
        pix[0] = 255;
        run_frame("corner00", 0, 1'b0, 0);

        for (int i = 0; i < N; i++) pix[i] = i % 256;
        run_frame("ramp_gap", 5, 1'b0, 0);

        for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(0, 255));
        run_frame("rand_gap", 5, 1'b0, 0);

        for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(0, 255));
        run_frame("rand_inject", 2, 1'b1, 1);

        for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(1, 255));
        drive(2 * W + 4, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(dv), 0);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_fd", int'(fd), 0);
        chk("midrst_ovr", int'(ovr), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(0, 255));
        run_frame("post_rst", 3, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
